// File: rtl/dispatch_queue.sv
// ---------------------------------------------------------------------------
// dispatch_queue
//
// In-order, multi-ported circular buffer between rename and the issue
// queues. Each cycle it accepts up to DISP_WIDTH renamed uops as one group
// and presents the DISP_WIDTH oldest entries to dispatch. A stalled issue
// queue therefore never stalls rename partway through a group.
//
// Parameters
//   DISP_WIDTH : uop slots per cycle on enqueue and dequeue sides
//   DEPTH      : entries (power of two, DEPTH >= 2*DISP_WIDTH)
//   UOP_WIDTH  : bits per flattened renamed uop
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset (pointers and count only)
//   in_valid   : per-slot valid from rename, gaps allowed
//   in_uop     : slot k at [k*UOP_WIDTH +: UOP_WIDTH]
//   in_ready   : whole group is accepted this cycle when high
//   out_valid  : slot k holds the k-th oldest entry
//   out_uop    : uops at head+k
//   out_ready  : per-slot consume request; only a leading run from slot 0
//                actually dequeues
//   flush      : synchronous squash of all contents, beats enq/deq
//   count      : current occupancy
// ---------------------------------------------------------------------------
module dispatch_queue #(
    parameter int DISP_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int UOP_WIDTH  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DISP_WIDTH-1:0]           in_valid,
    input  logic [DISP_WIDTH*UOP_WIDTH-1:0] in_uop,
    output logic                            in_ready,
    output logic [DISP_WIDTH-1:0]           out_valid,
    output logic [DISP_WIDTH*UOP_WIDTH-1:0] out_uop,
    input  logic [DISP_WIDTH-1:0]           out_ready,
    input  logic                            flush,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [UOP_WIDTH-1:0] mem [DEPTH];

    logic [CW:0]           free_slots;
    logic [DISP_WIDTH-1:0] enq_mask;
    logic [PW-1:0]         enq_off [DISP_WIDTH];
    logic [PW-1:0]         enq_acc;
    logic [CW-1:0]         n_enq;
    logic [CW-1:0]         n_deq;
    logic                  deq_run;
    logic [CW-1:0]         count_next;

    // Group admission looks only at registered occupancy, so in_ready has
    // no combinational path from out_ready or in_valid. A nearly-full queue
    // refuses even a single-valid group (conservative whole-group rule).
    always_comb begin
        free_slots = (CW+1)'(DEPTH) - {1'b0, count};
        in_ready   = (free_slots >= (CW+1)'(DISP_WIDTH));
    end

    // Valid slots are compacted: each valid slot's write offset is the
    // number of valid slots below it.
    always_comb begin
        enq_mask = in_valid & {DISP_WIDTH{in_ready}};
        enq_acc  = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            enq_off[k] = enq_acc;
            if (enq_mask[k]) begin
                enq_acc = enq_acc + 1'b1;
            end
        end
        n_enq = CW'(enq_acc);
    end

    // Dequeue is strictly in order: count the leading run of consumed slots.
    always_comb begin
        deq_run = 1'b1;
        n_deq   = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            deq_run = deq_run & out_valid[k] & out_ready[k];
            if (deq_run) begin
                n_deq = n_deq + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
            out_valid[k]                         = (count > CW'(k));
            out_uop[k*UOP_WIDTH +: UOP_WIDTH]    = mem[head + PW'(k)];
        end
    end

    assign count_next = count + n_enq - n_deq;

    // Pointer / occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq);
            count <= count_next;
        end
    end

    // Entry storage carries no reset; contents are only observed through
    // out_valid, which is governed by count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (enq_mask[k] && !flush) begin
                mem[tail + enq_off[k]] <= in_uop[k*UOP_WIDTH +: UOP_WIDTH];
            end
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));

    a_deq_needs_head : assert property (@(posedge clk) disable iff (rst)
        (n_deq != '0) |-> out_valid[0]);

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   in_valid;
    logic [127:0] in_uop;
    logic         in_ready;
    logic [1:0]   out_valid;
    logic [127:0] out_uop;
    logic [1:0]   out_ready;
    logic         flush;
    logic [4:0]   count;

    dispatch_queue #(.DISP_WIDTH(2), .DEPTH(16), .UOP_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_uop(in_uop), .in_ready(in_ready),
        .out_valid(out_valid), .out_uop(out_uop), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    logic [63:0] q[$];
    int mcount = 0;
    int total = 0;
    int bad = 0;
    int mon_total = 0;
    int mon_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Checks state left by the previous edge, then applies one cycle of
    // stimulus and updates the reference model / scoreboard.
    task automatic step(input logic [1:0] iv, input logic [63:0] u0, input logic [63:0] u1,
                        input logic [1:0] ordy, input logic fl);
        logic [1:0] ev;
        logic rdy;
        int nd;
        int ne;
        @(posedge clk); #1;
        ev  = {mcount > 1, mcount > 0};
        rdy = (16 - mcount) >= 2;
        chk("count", 64'(count), 64'(mcount));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (mcount > 0) chk("slot0", out_uop[63:0], q[0]);
        if (mcount > 1) chk("slot1", out_uop[127:64], q[1]);
        in_valid  = iv;
        in_uop    = {u1, u0};
        out_ready = ordy;
        flush     = fl;
        nd = 0;
        if (ordy[0] && mcount > 0) begin
            nd = 1;
            if (ordy[1] && mcount > 1) nd = 2;
        end
        if (fl) begin
            q.delete();
            mcount = 0;
        end else begin
            ne = 0;
            if (rdy) begin
                if (iv[0]) begin q.push_back(u0); ne++; end
                if (iv[1]) begin q.push_back(u1); ne++; end
            end
            mcount = mcount + ne - nd;
        end
    endtask

    task automatic idle();
        step(2'b00, 64'h0, 64'h0, 2'b00, 1'b0);
    endtask

    // Monitor: pops the scoreboard for every slot the DUT actually hands out.
    initial begin
        logic run;
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && !flush) begin
                run = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    run = run && out_valid[k] && out_ready[k];
                    if (run) begin
                        mon_total++;
                        if (q.size() == 0) begin
                            mon_bad++;
                            $display("FAIL deq_extra slot%0d got=%0h want=none", k, out_uop[k*64 +: 64]);
                        end else begin
                            exp = q.pop_front();
                            if (out_uop[k*64 +: 64] !== exp) begin
                                mon_bad++;
                                $display("FAIL deq_order slot%0d got=%0h want=%0h", k, out_uop[k*64 +: 64], exp);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int iter;
        logic rdy;
        rst = 1'b1; in_valid = '0; in_uop = '0; out_ready = '0; flush = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        @(negedge clk); rst = 1'b0;

        // A,B then gapped C in slot 1
        step(2'b11, 64'hA, 64'hB, 2'b00, 1'b0);
        step(2'b10, 64'h0, 64'hC, 2'b00, 1'b0);
        // fill to 15
        for (int i = 0; i < 6; i++) step(2'b11, 64'h100 + 64'(2*i), 64'h101 + 64'(2*i), 2'b00, 1'b0);
        // full: D,E dropped
        step(2'b11, 64'hD, 64'hE, 2'b00, 1'b0);
        step(2'b00, 64'h0, 64'h0, 2'b01, 1'b0);
        idle();
        chk("after_pop_count", 64'(count), 64'd14);
        chk("after_pop_ready", 64'(in_ready), 64'h1);
        // drain to 4
        for (int i = 0; i < 5; i++) step(2'b00, 64'h0, 64'h0, 2'b11, 1'b0);
        step(2'b00, 64'h0, 64'h0, 2'b10, 1'b0);
        step(2'b00, 64'h0, 64'h0, 2'b11, 1'b0);
        step(2'b00, 64'h0, 64'h0, 2'b11, 1'b0);
        idle();

        // wrap-around stream of 40 tags with random ready prefixes
        sent = 0;
        iter = 0;
        while ((sent < 40 || mcount > 0) && iter < 600) begin
            rdy = (16 - mcount) >= 2;
            if (sent < 39) begin
                step(2'b11, 64'(sent), 64'(sent + 1), 2'($urandom_range(0, 3)), 1'b0);
                if (rdy) sent += 2;
            end else if (sent == 39) begin
                step(2'b01, 64'd39, 64'h0, 2'($urandom_range(0, 3)), 1'b0);
                if (rdy) sent += 1;
            end else begin
                step(2'b00, 64'h0, 64'h0, 2'($urandom_range(1, 3)), 1'b0);
            end
            iter++;
        end
        total++;
        if (iter >= 600) begin
            bad++;
            $display("FAIL wrap_drain got=iter%0d want=drained", iter);
        end
        idle();
        chk("wrap_sb_empty", 64'(q.size()), 64'h0);

        // flush with count=9 and enqueue/dequeue in the same cycle
        for (int i = 0; i < 4; i++) step(2'b11, 64'h200 + 64'(2*i), 64'h201 + 64'(2*i), 2'b00, 1'b0);
        step(2'b01, 64'h208, 64'h0, 2'b00, 1'b0);
        step(2'b11, 64'hF0, 64'hF1, 2'b11, 1'b1);
        step(2'b11, 64'h300, 64'h301, 2'b00, 1'b0);
        step(2'b00, 64'h0, 64'h0, 2'b01, 1'b0);
        step(2'b11, 64'h400, 64'h401, 2'b00, 1'b0);
        idle();

        // async reset mid-stream
        @(posedge clk); #1;
        chk("pre_rst_count", 64'(count), 64'(mcount));
        in_valid = '0; out_ready = '0; flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'h0);
        chk("async_in_ready", 64'(in_ready), 64'h1);
        chk("async_count", 64'(count), 64'h0);
        q.delete();
        mcount = 0;
        @(negedge clk); rst = 1'b0;
        step(2'b11, 64'h500, 64'h501, 2'b00, 1'b0);
        step(2'b00, 64'h0, 64'h0, 2'b11, 1'b0);
        idle();
        idle();
        chk("final_sb_empty", 64'(q.size()), 64'h0);

        total += mon_total;
        bad   += mon_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- In-order, multi-ported buffer between the rename stage and the issue queues.
- Each cycle it accepts up to DISP_WIDTH renamed uops (physical-register sources/destination already resolved) and presents up to DISP_WIDTH oldest uops to dispatch.
- Decouples rename from issue-queue backpressure, so a stalled issue queue does not force the free-preg pop/RAT write path to stall mid-group.

Parameters:
- DISP_WIDTH, 2, uop slots per cycle on both the enqueue and dequeue sides.
- DEPTH, 16, entries; power of two, and DEPTH >= 2*DISP_WIDTH.
- UOP_WIDTH, 64, bits per flattened renamed uop.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  DISP_WIDTH  per-slot valid from rename; gaps allowed, e.g. 2'b10.
- in_uop  input  DISP_WIDTH*UOP_WIDTH  slot k occupies bits [k*UOP_WIDTH +: UOP_WIDTH].
- in_ready  output  1  whole group accepted this cycle when high.
- out_valid  output  DISP_WIDTH  slot k holds the (k)th-oldest entry.
- out_uop  output  DISP_WIDTH*UOP_WIDTH  uops at head+k.
- out_ready  input  DISP_WIDTH  per-slot consume request from dispatch.
- flush  input  1  synchronous squash of all contents.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - head=0, tail=0, count=0.
  - out_valid=0, in_ready=1.
  - Entry storage is not reset; out_uop is don't-care while out_valid=0.
- in_ready:
  - in_ready = (DEPTH - count) >= DISP_WIDTH.
  - Depends on registered count only; no combinational path from out_ready or in_valid.
- Enqueue:
  - Occurs when in_ready=1; valid slots only.
  - Valid slots are compacted in slot order: the lowest-index valid slot goes to tail, the next to tail+1, and so on.
  - tail advances by popcount(in_valid & {DISP_WIDTH{in_ready}}).
  - When in_ready=0, inputs are ignored; rename must hold them.
- Dequeue:
  - out_valid[k] = (count > k); out_uop[k] = mem[(head+k) mod DEPTH].
  - Dequeue is strictly in order: n_deq = length of the leading run of ones in (out_valid & out_ready) starting at slot 0.
  - An out_ready[k] beyond the first zero in that run is ignored; e.g. out_ready=2'b10 dequeues nothing.
  - head advances by n_deq.
- Update order:
  - Enqueue and dequeue in the same cycle are both permitted.
  - count_next = count + n_enq - n_deq.
  - Pointers wrap mod DEPTH (natural $clog2(DEPTH) overflow).
- Latency:
  - A uop written at edge T is visible on out_* from T+1; no same-cycle bypass from input to output.
  - On an empty queue, the minimum enqueue-to-dispatch latency is 1 cycle.
- Full/empty:
  - count=DEPTH forces in_ready=0.
  - count=DEPTH-1 with DISP_WIDTH=2 also forces in_ready=0, even if only one slot is valid (conservative group rule).
  - count=0 forces all out_valid=0.
- Flush:
  - On the next edge: head=tail=count=0.
  - Same-cycle enqueue and dequeue are discarded; flush has priority over both.
  - in_ready is still evaluated normally during the flush cycle, but nothing is written.
- Reset mid-operation:
  - Immediate asynchronous clear to the reset state regardless of handshakes in flight.
- Assertions:
  - count <= DEPTH at all times.
  - No dequeue while out_valid[0]=0.

Test Plan:
- Reset, then enqueue in_valid=2'b11 with uops A,B -> next cycle out_valid=2'b11, out_uop slot0=A, slot1=B, count=2.
- Gapped input: in_valid=2'b10 with uop C in slot1, out_ready=0 -> C lands at the entry after B, count=3, out slot0 still A.
- Fill to count=15 with out_ready=0 -> in_ready=0; in_valid=2'b11 with D,E -> D and E dropped, count stays 15; then out_ready=2'b01 for one cycle -> count=14, in_ready=1.
- Out-of-order ready: out_ready=2'b10 with count=4 -> no dequeue, head unchanged; out_ready=2'b11 -> head+=2, count=2.
- Wrap-around: stream 40 uops tagged 0..39 with random out_ready prefixes -> output order exactly 0..39, with no loss or duplication across pointer wrap.
- flush asserted with count=9, in_valid=2'b11, out_ready=2'b11 -> next cycle count=0, out_valid=0; an enqueue in the following cycle appears at out slot0; async rst pulse mid-stream -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
